// File: rtl/player_sprite_ctrl.sv
// Player sprite: position/clamping, scan-window ROM addressing with one-cycle pixel alignment,
// and a lives/invincibility FSM (ALIVE -> INVINC -> ALIVE ... -> DEAD).
module player_sprite_ctrl #(
    parameter int          SPR_W     = 50,
    parameter int          SPR_H     = 50,
    parameter int          SCR_W     = 640,
    parameter int          SCR_H     = 480,
    parameter int          STEP      = 1,
    parameter int          LIVES     = 3,
    parameter int          INV_TICKS = 120,
    parameter logic [11:0] TRANSP    = 12'hFFF,
    parameter logic [11:0] BLINK_RGB = 12'h08F,
    parameter int          ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              move_tick,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [3:0]        direction,
    input  logic              boom,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_rgb,
    output logic [9:0]        p_x,
    output logic [9:0]        p_y,
    output logic              en,
    output logic [11:0]       rgb,
    output logic [3:0]        lives,
    output logic [1:0]        state,
    output logic              dead
);

    typedef enum logic [1:0] {
        StAlive  = 2'd0,
        StInvinc = 2'd1,
        StDead   = 2'd2
    } state_e;

    localparam logic [9:0]        X_MAX   = 10'(SCR_W - SPR_W);
    localparam logic [9:0]        Y_MAX   = 10'(SCR_H - SPR_H);
    localparam logic [9:0]        X_RST   = 10'(SCR_W / 2 - SPR_W / 2);
    localparam logic [9:0]        Y_RST   = 10'(SCR_H - SPR_H);
    localparam logic [9:0]        STEP_V  = 10'(STEP);
    localparam logic [10:0]       SPR_W_X = 11'(SPR_W);
    localparam logic [10:0]       SPR_H_X = 11'(SPR_H);
    localparam logic [ADDR_W-1:0] SPR_W_A = ADDR_W'(SPR_W);
    localparam logic [3:0]        LIVES_V = 4'(LIVES);
    localparam logic [7:0]        INV_V   = 8'(INV_TICKS);

    state_e      r_state;
    logic [7:0]  r_inv_cnt;
    logic        r_win_d;

    logic        w_up, w_down, w_left, w_right;
    logic [10:0] w_px_sum, w_py_sum;
    logic [9:0]  w_px_next, w_py_next;
    logic [9:0]  w_dx, w_dy;
    logic        w_win;

    // Opposing direction bits cancel on their axis.
    assign w_up    = direction[0] & ~direction[1];
    assign w_down  = direction[1] & ~direction[0];
    assign w_left  = direction[2] & ~direction[3];
    assign w_right = direction[3] & ~direction[2];

    assign w_px_sum = {1'b0, p_x} + {1'b0, STEP_V};
    assign w_py_sum = {1'b0, p_y} + {1'b0, STEP_V};

    always_comb begin
        w_px_next = p_x;
        w_py_next = p_y;
        if (w_left) begin
            w_px_next = (p_x >= STEP_V) ? p_x - STEP_V : 10'd0;
        end else if (w_right) begin
            w_px_next = (w_px_sum > {1'b0, X_MAX}) ? X_MAX : w_px_sum[9:0];
        end
        if (w_up) begin
            w_py_next = (p_y >= STEP_V) ? p_y - STEP_V : 10'd0;
        end else if (w_down) begin
            w_py_next = (w_py_sum > {1'b0, Y_MAX}) ? Y_MAX : w_py_sum[9:0];
        end
    end

    assign w_dx     = x - p_x;
    assign w_dy     = y - p_y;
    assign rom_addr = ADDR_W'(w_dy) * SPR_W_A + ADDR_W'(w_dx);

    assign w_win = (x >= p_x) && ({1'b0, x} < ({1'b0, p_x} + SPR_W_X)) &&
                   (y >= p_y) && ({1'b0, y} < ({1'b0, p_y} + SPR_H_X));

    // Position and window flag; movement sees the pre-transition FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_x     <= X_RST;
            p_y     <= Y_RST;
            r_win_d <= 1'b0;
        end else begin
            if (move_tick && (r_state != StDead)) begin
                p_x <= w_px_next;
                p_y <= w_py_next;
            end
            r_win_d <= w_win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StAlive;
            lives     <= LIVES_V;
            r_inv_cnt <= 8'd0;
        end else begin
            case (r_state)
                StAlive: begin
                    if (boom) begin
                        if (lives > 4'd1) begin
                            lives     <= lives - 4'd1;
                            r_inv_cnt <= INV_V;
                            r_state   <= StInvinc;
                        end else begin
                            lives   <= 4'd0;
                            r_state <= StDead;
                        end
                    end
                end
                StInvinc: begin
                    if (move_tick) begin
                        if (r_inv_cnt <= 8'd1) begin
                            r_inv_cnt <= 8'd0;
                            r_state   <= StAlive;
                        end else begin
                            r_inv_cnt <= r_inv_cnt - 8'd1;
                        end
                    end
                end
                StDead: r_state <= StDead;
                default: r_state <= StDead;
            endcase
        end
    end

    assign en    = r_win_d && (rom_rgb != TRANSP) && (r_state != StDead);
    assign rgb   = ((r_state == StInvinc) && r_inv_cnt[3]) ? BLINK_RGB : rom_rgb;
    assign state = r_state;
    assign dead  = (r_state == StDead);

endmodule

// File: tb/tb_player_sprite_ctrl.sv
// Directed bench for player_sprite_ctrl: movement/clamping, FSM lives/invincibility,
// pixel pipeline and asynchronous reset, with hand-computed expectations.
module tb_player_sprite_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        move_tick;
    logic [9:0]  x, y;
    logic [3:0]  direction;
    logic        boom;
    logic [11:0] rom_addr;
    logic [11:0] rom_rgb;
    logic [9:0]  p_x, p_y;
    logic        en;
    logic [11:0] rgb;
    logic [3:0]  lives;
    logic [1:0]  state;
    logic        dead;

    int n_checks = 0;
    int n_pass   = 0;

    player_sprite_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .move_tick (move_tick),
        .x         (x),
        .y         (y),
        .direction (direction),
        .boom      (boom),
        .rom_addr  (rom_addr),
        .rom_rgb   (rom_rgb),
        .p_x       (p_x),
        .p_y       (p_y),
        .en        (en),
        .rgb       (rgb),
        .lives     (lives),
        .state     (state),
        .dead      (dead)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        move_tick = 1'b1;
        repeat (n) step();
        move_tick = 1'b0;
    endtask

    task automatic pulse_boom();
        boom = 1'b1;
        step();
        boom = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; move_tick = 1'b0; x = 10'd0; y = 10'd0;
        direction = 4'b0000; boom = 1'b0; rom_rgb = 12'h123;
        #1;
        check("rst_px", 32'(p_x), 32'd295);
        check("rst_py", 32'(p_y), 32'd430);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_dead", 32'(dead), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        #2 rst = 1'b0;
        step();

        // Left run to the edge and hold.
        direction = 4'b0100;
        do_ticks(1);
        check("left_first", 32'(p_x), 32'd294);
        do_ticks(294);
        check("left_zero", 32'(p_x), 32'd0);
        do_ticks(5);
        check("left_hold", 32'(p_x), 32'd0);
        check("left_py", 32'(p_y), 32'd430);

        // Diagonal, cancellation, no-tick and clamps.
        do_reset();
        direction = 4'b1001;
        do_ticks(10);
        check("diag_px", 32'(p_x), 32'd305);
        check("diag_py", 32'(p_y), 32'd420);
        direction = 4'b0011;
        do_ticks(5);
        check("cancel_y", 32'(p_y), 32'd420);
        direction = 4'b1100;
        do_ticks(5);
        check("cancel_x", 32'(p_x), 32'd305);
        direction = 4'b1000;
        repeat (3) step();
        check("no_tick", 32'(p_x), 32'd305);
        do_ticks(300);
        check("right_clamp", 32'(p_x), 32'd590);
        direction = 4'b0010;
        do_ticks(10);
        check("down_reach", 32'(p_y), 32'd430);
        do_ticks(10);
        check("down_clamp", 32'(p_y), 32'd430);

        // Hit, invincibility, ignored second hit, blink colour.
        do_reset();
        direction = 4'b0000;
        rom_rgb = 12'h123;
        pulse_boom();
        check("boom1_lives", 32'(lives), 32'd2);
        check("boom1_state", 32'(state), 32'd1);
        check("blink_on", 32'(rgb), 32'h08F);
        do_ticks(5);
        check("blink_off", 32'(rgb), 32'h123);
        pulse_boom();
        check("boom_ignored", 32'(lives), 32'd2);
        do_ticks(114);
        check("inv_still", 32'(state), 32'd1);
        do_ticks(1);
        check("inv_expired", 32'(state), 32'd0);

        // Hit and tick in one cycle: moves, fresh timer (120 has bit3 set, 119 not).
        direction = 4'b0100;
        move_tick = 1'b1;
        pulse_boom();
        move_tick = 1'b0;
        check("same_cyc_px", 32'(p_x), 32'd294);
        check("same_cyc_lives", 32'(lives), 32'd1);
        check("same_cyc_timer", 32'(rgb), 32'h08F);
        direction = 4'b0000;
        do_ticks(119);
        check("inv2_still", 32'(state), 32'd1);
        do_ticks(1);
        check("inv2_expired", 32'(state), 32'd0);
        pulse_boom();
        check("dead_lives", 32'(lives), 32'd0);
        check("dead_flag", 32'(dead), 32'd1);
        check("dead_state", 32'(state), 32'd2);
        x = 10'd294; y = 10'd430;
        direction = 4'b1001;
        do_ticks(5);
        pulse_boom();
        check("dead_px", 32'(p_x), 32'd294);
        check("dead_py", 32'(p_y), 32'd430);
        check("dead_en", 32'(en), 32'd0);
        check("dead_lives2", 32'(lives), 32'd0);

        // Pixel pipeline.
        do_reset();
        direction = 4'b0000;
        x = 10'd295; y = 10'd430;
        #1;
        check("addr_origin", 32'(rom_addr), 32'd0);
        check("en_pre_edge", 32'(en), 32'd0);
        step();
        rom_rgb = 12'h123;
        #1;
        check("pix_en", 32'(en), 32'd1);
        check("pix_rgb", 32'(rgb), 32'h123);
        rom_rgb = 12'hFFF;
        #1;
        check("pix_transp", 32'(en), 32'd0);
        x = 10'd298; y = 10'd432;
        #1;
        check("addr_mid", 32'(rom_addr), 32'd103);
        rom_rgb = 12'h123;
        x = 10'd345; y = 10'd430;
        step();
        check("pix_right_out", 32'(en), 32'd0);
        x = 10'd344; y = 10'd479;
        step();
        check("pix_last", 32'(en), 32'd1);
        x = 10'd294;
        step();
        check("pix_left_out", 32'(en), 32'd0);

        // Asynchronous reset mid-invincibility.
        do_reset();
        direction = 4'b0100;
        do_ticks(195);
        check("pre_rst_px", 32'(p_x), 32'd100);
        pulse_boom();
        check("pre_rst_state", 32'(state), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_px", 32'(p_x), 32'd295);
        check("arst_py", 32'(p_y), 32'd430);
        check("arst_state", 32'(state), 32'd0);
        check("arst_lives", 32'(lives), 32'd3);
        check("arst_en", 32'(en), 32'd0);
        #1 rst = 1'b0;
        step();
        do_ticks(1);
        check("post_rst_tick", 32'(p_x), 32'd294);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
